// File: rtl/seq_arith_unit.sv
// Sequential unsigned arithmetic unit: single-cycle add/sub/mul and a restoring
// divider that retires one quotient bit per clock, with a valid/ready result handshake.
module seq_arith_unit #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [1:0]           i_op,
    input  logic [WIDTH-1:0]     i_value_a,
    input  logic [WIDTH-1:0]     i_value_b,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [2*WIDTH-1:0]   o_result,
    output logic [WIDTH-1:0]     o_remainder,
    output logic                 o_div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic                 ready_reg, ready_next;
    logic                 valid_reg, valid_next;
    logic [2*WIDTH-1:0]   result_reg, result_next;
    logic [WIDTH-1:0]     remainder_reg, remainder_next;
    logic                 dbz_reg, dbz_next;
    logic [WIDTH-1:0]     quo_reg, quo_next;
    logic [WIDTH-1:0]     rem_reg, rem_next;
    logic [WIDTH-1:0]     divisor_reg, divisor_next;
    logic [CW-1:0]        count_reg, count_next;

    logic [WIDTH:0]       sum_w, diff_w, shifted_w, trial_w;
    logic [2*WIDTH-1:0]   prod_w;
    logic                 step_fit;
    logic [WIDTH-1:0]     step_rem, step_quo;

    assign sum_w  = {1'b0, i_value_a} + {1'b0, i_value_b};
    assign diff_w = {1'b0, i_value_a} - {1'b0, i_value_b};
    assign prod_w = {{WIDTH{1'b0}}, i_value_a} * {{WIDTH{1'b0}}, i_value_b};

    // One restoring step: shift in the next dividend bit, keep the subtraction if it fits.
    assign shifted_w = {rem_reg, quo_reg[WIDTH-1]};
    assign trial_w   = shifted_w - {1'b0, divisor_reg};
    assign step_fit  = ~trial_w[WIDTH];
    assign step_rem  = step_fit ? trial_w[WIDTH-1:0] : shifted_w[WIDTH-1:0];
    assign step_quo  = {quo_reg[WIDTH-2:0], step_fit};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            ready_reg     <= 1'b1;
            valid_reg     <= 1'b0;
            result_reg    <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
            quo_reg       <= '0;
            rem_reg       <= '0;
            divisor_reg   <= '0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            ready_reg     <= ready_next;
            valid_reg     <= valid_next;
            result_reg    <= result_next;
            remainder_reg <= remainder_next;
            dbz_reg       <= dbz_next;
            quo_reg       <= quo_next;
            rem_reg       <= rem_next;
            divisor_reg   <= divisor_next;
            count_reg     <= count_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        result_next    = result_reg;
        remainder_next = remainder_reg;
        dbz_next       = dbz_reg;
        quo_next       = quo_reg;
        rem_next       = rem_reg;
        divisor_next   = divisor_reg;
        count_next     = count_reg;

        case (state_reg)
            IDLE: begin
                if (i_valid && ready_reg) begin
                    state_next     = DONE;
                    remainder_next = '0;
                    dbz_next       = 1'b0;
                    case (i_op)
                        2'd0: result_next = {{(WIDTH-1){1'b0}}, sum_w};
                        2'd1: result_next = {{(WIDTH-1){1'b0}}, diff_w};
                        2'd2: result_next = prod_w;
                        default: begin
                            if (i_value_b == '0) begin
                                result_next    = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                                remainder_next = i_value_a;
                                dbz_next       = 1'b1;
                            end else begin
                                // Previous result stays on the outputs while dividing.
                                state_next     = CALC;
                                result_next    = result_reg;
                                remainder_next = remainder_reg;
                                dbz_next       = dbz_reg;
                                quo_next       = i_value_a;
                                rem_next       = '0;
                                divisor_next   = i_value_b;
                                count_next     = '0;
                            end
                        end
                    endcase
                end
            end
            CALC: begin
                quo_next   = step_quo;
                rem_next   = step_rem;
                count_next = count_reg + 1'b1;
                if (count_reg == LAST_STEP) begin
                    state_next     = DONE;
                    result_next    = {{WIDTH{1'b0}}, step_quo};
                    remainder_next = step_rem;
                    dbz_next       = 1'b0;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        ready_next = (state_next == IDLE);
        valid_next = (state_next == DONE);
    end

    assign o_ready       = ready_reg;
    assign o_valid       = valid_reg;
    assign o_result      = result_reg;
    assign o_remainder   = remainder_reg;
    assign o_div_by_zero = dbz_reg;

endmodule
